mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the mips_core execute stage.
- Parametrised successor of the current fixed-width single-shot mult/div path.
- Executes MULT/DIV (optionally MULTU/DIVU) iteratively, one bit per cycle, and services MTHI/MTLO writes.
- Raises busy so the core can stall MFHI/MFLO and new mult/div ops until results are committed.

Parameters:
- DATA_WIDTH, 32: operand and HI/LO width; must be even and >= 8.
- CNT_WIDTH, $clog2(DATA_WIDTH): iteration counter width; derived, do not override.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- start  in  1  request; sampled only when busy=0.
- op  in  3  0=MULT, 1=DIV, 2=MTHI, 3=MTLO, 4=MULTU, 5=DIVU, others=no-op.
- src_a  in  DATA_WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- src_b  in  DATA_WIDTH  rt operand (divisor / multiplier).
- busy  out  1  high while an arithmetic op is in flight.
- done  out  1  one-cycle pulse when HI/LO are committed by an arithmetic op.
- div_by_zero  out  1  one-cycle pulse coincident with done, DIV/DIVU with src_b=0.
- hi  out  DATA_WIDTH  architectural HI.
- lo  out  DATA_WIDTH  architectural LO.

Behaviour:
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0.
- Reset asserted mid-operation aborts the op; no commit.
- FSM has three states: IDLE, CALC, FIX. busy = (state != IDLE).
- IDLE:
  - start with MULT/DIV/MULTU/DIVU latches operand magnitudes and result signs, counter=DATA_WIDTH-1, then goes to CALC.
  - start with MTHI/MTLO writes src_a into hi/lo at that edge and stays IDLE; there is no done pulse.
  - start with an illegal op is ignored.
- CALC:
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring, one quotient bit per cycle.
  - Counter decrements each cycle; at 0 go to FIX.
  - CALC lasts exactly DATA_WIDTH cycles.
- FIX:
  - Apply sign correction and write hi/lo. Multiply writes the 2*DATA_WIDTH product as {hi,lo}. Divide writes lo=quotient, hi=remainder.
  - done=1 in the following cycle. Return to IDLE.
- Latency: start edge at T0; hi/lo update and done asserts at edge T0+DATA_WIDTH+1. busy is high from T0 up to, but not including, that edge. Back-to-back start is accepted in the cycle done is high.
- Signed rules:
  - Product is the two's-complement full-width result.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN_INT / -1 gives lo=MIN_INT, hi=0, with no flag.
- Divide by zero: full latency preserved; lo=all ones, hi=src_a; div_by_zero pulses with done.
- start while busy=1 is ignored, including MTHI/MTLO; the core must stall.
- hi/lo hold their old values throughout CALC; they change only at the FIX commit or an MTHI/MTLO edge.

Optional Feature:
- MIPS_MULDIV_UNSIGNED_EN defined: op 4/5 perform MULTU/DIVU, with operands treated as unsigned, no sign fix-up, and the same latency and div-by-zero rule.
- Not defined: op 4/5 decode as no-op (ignored like illegal ops); unsigned datapath logic removed.

Test Plan (DATA_WIDTH=32):
- MULT src_a=7, src_b=0xFFFFFFFD -> busy 33 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div_by_zero=0.
- DIV src_a=5, src_b=0 -> after 33 cycles: lo=0xFFFFFFFF, hi=5; div_by_zero and done pulse together.
- MTHI 0x1234 then MTLO 0xABCD while idle -> hi=0x1234, lo=0xABCD next edge; no done. Repeating MTHI 0x9999 while busy -> hi unchanged.
- Start MULT 3*4, assert rst at cycle 10 -> hi=lo=0, busy=0 immediately. Re-issue -> lo=12 after 33 cycles.
- With macro: MULTU 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE. Without macro: same request ignored, busy stays 0.

Source files
------------

// File: rtl/mips_muldiv_unit_if.sv
// Core <-> multiply/divide unit connection: request fields, status and HI/LO.
interface mips_muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/DIV unit with HI/LO, one bit per cycle.
// Define MIPS_MULDIV_UNSIGNED_EN to enable MULTU/DIVU (op 4/5).
module mips_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  mips_muldiv_unit_if.slave md_io
);
  // state  | meaning
  // S_IDLE | waiting for start; MTHI/MTLO handled here
  // S_CALC | one multiplier/quotient bit per cycle
  // S_FIX  | sign correction and HI/LO commit
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  localparam int DW = DATA_WIDTH;
  localparam logic [2:0] OP_MULT = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_MTHI = 3'd2;
  localparam logic [2:0] OP_MTLO = 3'd3;
`ifdef MIPS_MULDIV_UNSIGNED_EN
  localparam logic [2:0] OP_MULTU = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
`endif

  state_e              state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2*DW-1:0]     acc_q, acc_d;
  logic [DW-1:0]       opd_q, opd_d;
  logic                is_div_q, is_div_d;
  logic                neg_lo_q, neg_lo_d;
  logic                neg_hi_q, neg_hi_d;
  logic                dbz_pend_q, dbz_pend_d;
  logic [DW-1:0]       hi_q, hi_d;
  logic [DW-1:0]       lo_q, lo_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;

  logic          mul_op, div_op, signed_op;
  logic          a_neg, b_neg;
  logic [DW-1:0] a_mag, b_mag;
  logic [DW:0]   mul_sum, div_shift, div_diff;
  logic          div_ok;
  logic [2*DW-1:0] prod_neg;
  logic [DW-1:0] quo, rem;

  always_comb begin
    mul_op    = (md_io.op == OP_MULT);
    div_op    = (md_io.op == OP_DIV);
    signed_op = 1'b1;
`ifdef MIPS_MULDIV_UNSIGNED_EN
    if (md_io.op == OP_MULTU) begin
      mul_op    = 1'b1;
      signed_op = 1'b0;
    end
    if (md_io.op == OP_DIVU) begin
      div_op    = 1'b1;
      signed_op = 1'b0;
    end
`endif
  end

  assign a_neg = signed_op & md_io.src_a[DW-1];
  assign b_neg = signed_op & md_io.src_b[DW-1];
  assign a_mag = a_neg ? (-md_io.src_a) : md_io.src_a;
  assign b_mag = b_neg ? (-md_io.src_b) : md_io.src_b;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign mul_sum   = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign div_shift = acc_q[2*DW-1:DW-1];
  assign div_diff  = div_shift - {1'b0, opd_q};
  assign div_ok    = ~div_diff[DW];
  assign prod_neg  = -acc_q;
  assign quo       = acc_q[DW-1:0];
  assign rem       = acc_q[2*DW-1:DW];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opd_d      = opd_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dbz_pend_d = dbz_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md_io.start) begin
          if (mul_op || div_op) begin
            state_d    = S_CALC;
            cnt_d      = CNT_WIDTH'(DW - 1);
            is_div_d   = div_op;
            acc_d      = {{DW{1'b0}}, (div_op ? a_mag : b_mag)};
            opd_d      = div_op ? b_mag : a_mag;
            neg_lo_d   = a_neg ^ b_neg;
            neg_hi_d   = a_neg;
            dbz_pend_d = div_op && (md_io.src_b == '0);
          end else if (md_io.op == OP_MTHI) begin
            hi_d = md_io.src_a;
          end else if (md_io.op == OP_MTLO) begin
            lo_d = md_io.src_a;
          end
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          acc_d = {(div_ok ? div_diff[DW-1:0] : div_shift[DW-1:0]),
                   acc_q[DW-2:0], div_ok};
        end else begin
          acc_d = {mul_sum, acc_q[DW-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          // divide-by-zero leaves rem = |dividend|, so the sign fix restores src_a
          lo_d = dbz_pend_q ? '1 : (neg_lo_q ? (-quo) : quo);
          hi_d = neg_hi_q ? (-rem) : rem;
        end else begin
          {hi_d, lo_d} = neg_lo_q ? prod_neg : acc_q;
        end
        done_d  = 1'b1;
        dbz_d   = dbz_pend_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opd_q      <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opd_q      <= opd_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dbz_pend_q <= dbz_pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign md_io.busy        = (state_q != S_IDLE);
  assign md_io.done        = done_q;
  assign md_io.div_by_zero = dbz_q;
  assign md_io.hi          = hi_q;
  assign md_io.lo          = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed vector bench for mips_muldiv_unit (DATA_WIDTH=32).
module tb_mips_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit_if #(.DATA_WIDTH(32)) bus ();

  mips_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .md_io (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // drive a one-cycle request starting now; returns #1 after the sampling edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // counts busy cycles (including the first) and checks HI/LO hold meanwhile
  task automatic wait_done(input string name, output int cyc);
    logic [31:0] h0, l0;
    logic        moved;
    h0 = bus.hi;
    l0 = bus.lo;
    moved = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      if (bus.hi !== h0 || bus.lo !== l0) moved = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, " hold"}, 64'(moved), 64'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz);
    int cyc;
    issue(op, a, b);
    check({name, " busy"}, 64'(bus.busy), 64'd1);
    wait_done(name, cyc);
    check({name, " cycles"}, 64'(cyc), 64'd33);
    check({name, " done"}, 64'(bus.done), 64'd1);
    check({name, " dbz"}, 64'(bus.div_by_zero), 64'(edbz));
    check({name, " hi"}, 64'(bus.hi), 64'(ehi));
    check({name, " lo"}, 64'(bus.lo), 64'(elo));
  endtask

  initial begin
    int cyc;
    vecs[0] = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1] = '{3'd1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[2] = '{3'd1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[5] = '{3'd1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[6] = '{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
    vecs[7] = '{3'd1, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{3'd1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[9] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};

    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset dbz", 64'(bus.div_by_zero), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // consecutive vectors are issued in the done cycle: back-to-back acceptance
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dbz);
    end
    @(posedge clk);
    #1;
    check("done pulse ends", 64'(bus.done), 64'd0);
    check("dbz pulse ends", 64'(bus.div_by_zero), 64'd0);

    issue(3'd2, 32'h0000_1234, 32'h0);
    check("mthi hi", 64'(bus.hi), 64'h1234);
    check("mthi busy", 64'(bus.busy), 64'd0);
    check("mthi done", 64'(bus.done), 64'd0);
    issue(3'd3, 32'h0000_ABCD, 32'h0);
    check("mtlo lo", 64'(bus.lo), 64'hABCD);
    check("mtlo hi kept", 64'(bus.hi), 64'h1234);
    check("mtlo done", 64'(bus.done), 64'd0);

    issue(3'd0, 32'd2, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    issue(3'd2, 32'h0000_9999, 32'h0);
    check("mthi while busy", 64'(bus.hi), 64'h1234);
    wait_done("mul 2x3", cyc);
    check("mul 2x3 cycles", 64'(cyc), 64'd29);
    check("mul 2x3 hi", 64'(bus.hi), 64'd0);
    check("mul 2x3 lo", 64'(bus.lo), 64'd6);

    // illegal op is ignored
    issue(3'd7, 32'h5, 32'h6);
    check("illegal busy", 64'(bus.busy), 64'd0);
    check("illegal lo", 64'(bus.lo), 64'd6);

    // async reset mid-operation
    issue(3'd2, 32'h0000_0055, 32'h0);
    issue(3'd0, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst hi", 64'(bus.hi), 64'd0);
    check("rst lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op("mul 3x4", 3'd0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

`ifdef MIPS_MULDIV_UNSIGNED_EN
    run_op("multu", 3'd4, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op("divu", 3'd5, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0);
    run_op("divu0", 3'd5, 32'h8000_0000, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
`else
    issue(3'd4, 32'hFFFF_FFFF, 32'd2);
    check("multu ignored busy", 64'(bus.busy), 64'd0);
    issue(3'd5, 32'hFFFF_FFFF, 32'd2);
    check("divu ignored busy", 64'(bus.busy), 64'd0);
    check("unsigned ignored lo", 64'(bus.lo), 64'd12);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
